// File: rtl/adder_arbiter.sv
// Round-robin front end for one shared registered adder: grants a requester,
// issues a one-cycle add, returns the sum with a one-cycle Ack.
module adder_arbiter #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned WIDTH = 4,
  parameter int unsigned ID_W  = 2
) (
  input  logic                   Clk,
  input  logic                   Rst,
  input  logic [N_REQ-1:0]       Req,
  input  logic [N_REQ*WIDTH-1:0] ReqA,
  input  logic [N_REQ*WIDTH-1:0] ReqB,
  output logic [N_REQ-1:0]       Ack,
  output logic [WIDTH-1:0]       Result,
  output logic                   ResultOvf,
  output logic [ID_W-1:0]        GntId,
  output logic                   Busy,
  output logic [WIDTH-1:0]       AddA,
  output logic [WIDTH-1:0]       AddB,
  output logic                   AddEn,
  input  logic [WIDTH-1:0]       AddSum,
  input  logic                   AddOverflow,
  output logic [7:0]             OvfCount
);

  localparam int unsigned CNT_W = 8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [ID_W-1:0]  ptr_q;
  logic [ID_W-1:0]  ptr_d;
  logic [ID_W-1:0]  winner;
  logic             found;
  int unsigned      idx;

  logic [N_REQ-1:0] ack_d;
  logic [WIDTH-1:0] result_d;
  logic             result_ovf_d;
  logic [ID_W-1:0]  gnt_id_d;
  logic             busy_d;
  logic [WIDTH-1:0] add_a_d;
  logic [WIDTH-1:0] add_b_d;
  logic             add_en_d;
  logic [CNT_W-1:0] ovf_count_d;

  // First requesting index at or after the round-robin pointer
  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      idx = (32'(ptr_q) + k) % N_REQ;
      if (!found && Req[idx]) begin
        found  = 1'b1;
        winner = ID_W'(idx);
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (found) state_d = S_ISSUE;
      S_ISSUE: state_d = S_WAIT;
      S_WAIT:  state_d = S_RESP;
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Next values of the registered outputs, one cycle ahead of the state they belong to
  always_comb begin
    ack_d        = '0;
    result_d     = Result;
    result_ovf_d = ResultOvf;
    gnt_id_d     = GntId;
    busy_d       = (state_d != S_IDLE);
    add_a_d      = AddA;
    add_b_d      = AddB;
    add_en_d     = 1'b0;
    ovf_count_d  = OvfCount;
    ptr_d        = ptr_q;
    case (state_q)
      S_IDLE: begin
        if (found) begin
          add_a_d  = ReqA[32'(winner) * WIDTH +: WIDTH];
          add_b_d  = ReqB[32'(winner) * WIDTH +: WIDTH];
          gnt_id_d = winner;
          add_en_d = 1'b1;
        end
      end
      S_ISSUE: ;
      S_WAIT: begin
        result_d     = AddSum;
        result_ovf_d = AddOverflow;
        if (AddOverflow && (OvfCount != {CNT_W{1'b1}}))
          ovf_count_d = OvfCount + CNT_W'(1);
        ack_d[GntId] = 1'b1;
      end
      S_RESP: begin
        if (32'(GntId) == N_REQ - 1) ptr_d = '0;
        else                         ptr_d = GntId + ID_W'(1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      ptr_q     <= '0;
      Ack       <= '0;
      Result    <= '0;
      ResultOvf <= 1'b0;
      GntId     <= '0;
      Busy      <= 1'b0;
      AddA      <= '0;
      AddB      <= '0;
      AddEn     <= 1'b0;
      OvfCount  <= '0;
    end else begin
      ptr_q     <= ptr_d;
      Ack       <= ack_d;
      Result    <= result_d;
      ResultOvf <= result_ovf_d;
      GntId     <= gnt_id_d;
      Busy      <= busy_d;
      AddA      <= add_a_d;
      AddB      <= add_b_d;
      AddEn     <= add_en_d;
      OvfCount  <= ovf_count_d;
    end
  end

endmodule

// File: tb/tb_adder_arbiter.sv
// Directed bench for adder_arbiter with a behavioural registered adder.
module tb_adder_arbiter;

  localparam int unsigned N_REQ = 4;
  localparam int unsigned WIDTH = 4;
  localparam int unsigned ID_W  = 2;

  logic                   Clk = 1'b0;
  logic                   Rst;
  logic [N_REQ-1:0]       Req;
  logic [N_REQ*WIDTH-1:0] ReqA;
  logic [N_REQ*WIDTH-1:0] ReqB;
  logic [N_REQ-1:0]       Ack;
  logic [WIDTH-1:0]       Result;
  logic                   ResultOvf;
  logic [ID_W-1:0]        GntId;
  logic                   Busy;
  logic [WIDTH-1:0]       AddA;
  logic [WIDTH-1:0]       AddB;
  logic                   AddEn;
  logic [WIDTH-1:0]       AddSum = '0;
  logic                   AddOverflow = 1'b0;
  logic [7:0]             OvfCount;

  int checks = 0;
  int errors = 0;
  int cycle  = 0;

  adder_arbiter #(.N_REQ(N_REQ), .WIDTH(WIDTH), .ID_W(ID_W)) dut (
    .Clk(Clk), .Rst(Rst), .Req(Req), .ReqA(ReqA), .ReqB(ReqB),
    .Ack(Ack), .Result(Result), .ResultOvf(ResultOvf), .GntId(GntId),
    .Busy(Busy), .AddA(AddA), .AddB(AddB), .AddEn(AddEn),
    .AddSum(AddSum), .AddOverflow(AddOverflow), .OvfCount(OvfCount)
  );

  always #5 Clk = ~Clk;

  // Shared adder: captures on the edge that ends an AddEn cycle
  always @(posedge Clk) begin
    if (AddEn) {AddOverflow, AddSum} <= {1'b0, AddA} + {1'b0, AddB};
  end

  typedef struct {
    int id; int a; int b; int res; int ovf; int cnt;
  } vec_t;
  vec_t vecs[5];

  task automatic tick();
    @(posedge Clk);
    #1;
    cycle++;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  task automatic do_reset();
    Rst = 1'b1; Req = '0; ReqA = '0; ReqB = '0;
    tick(); tick();
    Rst = 1'b0;
  endtask

  // One isolated op starting in IDLE; chg_a >= 0 rewrites operand A during ISSUE
  task automatic run_op(input int id, input int a, input int b, input int res,
                        input int ovf, input int cnt, input int chg_a);
    logic [N_REQ-1:0] onehot;
    onehot = '0;
    onehot[id] = 1'b1;
    Req = onehot;
    ReqA[id*WIDTH +: WIDTH] = WIDTH'(a);
    ReqB[id*WIDTH +: WIDTH] = WIDTH'(b);
    check("busy_idle", 32'(Busy), 0);
    tick();
    check("adden_issue", 32'(AddEn), 1);
    check("busy_issue", 32'(Busy), 1);
    check("gntid", 32'(GntId), 32'(id));
    check("adda", 32'(AddA), 32'(a));
    if (chg_a >= 0) ReqA[id*WIDTH +: WIDTH] = WIDTH'(chg_a);
    tick();
    check("adden_wait", 32'(AddEn), 0);
    check("ack_wait", 32'(Ack), 0);
    tick();
    check("ack_resp", 32'(Ack), 32'(onehot));
    check("result", 32'(Result), 32'(res));
    check("result_ovf", 32'(ResultOvf), 32'(ovf));
    check("ovf_count", 32'(OvfCount), 32'(cnt));
    Req = '0;
    tick();
    check("ack_after", 32'(Ack), 0);
    check("busy_after", 32'(Busy), 0);
    check("result_hold", 32'(Result), 32'(res));
  endtask

  task automatic wait_ack();
    int n;
    n = 0;
    while (Ack == '0 && n < 12) begin
      tick();
      n++;
    end
  endtask

  initial begin
    int last;
    int exp_cnt;

    vecs[0] = '{id: 2, a: 5,  b: 6, res: 11, ovf: 0, cnt: 0};
    vecs[1] = '{id: 1, a: 9,  b: 8, res: 1,  ovf: 1, cnt: 1};
    vecs[2] = '{id: 1, a: 15, b: 1, res: 0,  ovf: 1, cnt: 2};
    vecs[3] = '{id: 0, a: 7,  b: 8, res: 15, ovf: 0, cnt: 2};
    vecs[4] = '{id: 3, a: 0,  b: 0, res: 0,  ovf: 0, cnt: 2};

    do_reset();
    check("rst_ack", 32'(Ack), 0);
    check("rst_busy", 32'(Busy), 0);
    check("rst_adden", 32'(AddEn), 0);
    check("rst_result", 32'(Result), 0);
    check("rst_ovfcount", 32'(OvfCount), 0);

    // Reset asserted while the op is in WAIT: no Ack, everything cleared
    Req = 4'b0001;
    ReqA[0 +: WIDTH] = 4'd3;
    ReqB[0 +: WIDTH] = 4'd4;
    tick();
    tick();
    Rst = 1'b1;
    tick();
    Rst = 1'b0;
    Req = '0;
    check("midrst_ack", 32'(Ack), 0);
    check("midrst_busy", 32'(Busy), 0);
    check("midrst_adden", 32'(AddEn), 0);
    check("midrst_adda", 32'(AddA), 0);
    check("midrst_addb", 32'(AddB), 0);
    check("midrst_result", 32'(Result), 0);
    check("midrst_ovf", 32'(ResultOvf), 0);
    check("midrst_gnt", 32'(GntId), 0);
    tick();
    tick();
    check("midrst_no_late_ack", 32'(Ack), 0);

    for (int i = 0; i < 5; i++)
      run_op(vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].ovf, vecs[i].cnt, -1);

    // Operand change after grant has no effect
    run_op(3, 2, 2, 4, 0, 2, 7);

    // Round robin from Ptr=0 with all four requesting, then 1001
    do_reset();
    for (int i = 0; i < N_REQ; i++) begin
      ReqA[i*WIDTH +: WIDTH] = WIDTH'(i);
      ReqB[i*WIDTH +: WIDTH] = WIDTH'(1);
    end
    Req = 4'b1111;
    last = -1;
    for (int k = 0; k < 4; k++) begin
      wait_ack();
      check("rr_ack", 32'(Ack), 32'(1) << k);
      check("rr_result", 32'(Result), 32'(k + 1));
      if (last >= 0) check("rr_gap", 32'(cycle - last), 4);
      last = cycle;
      Req[k] = 1'b0;
      tick();
    end
    Req = 4'b1001;
    for (int k = 0; k < 2; k++) begin
      wait_ack();
      check("rr2_ack", 32'(Ack), (k == 0) ? 32'd1 : 32'd8);
      check("rr2_gap", 32'(cycle - last), 4);
      last = cycle;
      Req[(k == 0) ? 0 : 3] = 1'b0;
      tick();
    end

    // Overflow counter saturation
    do_reset();
    exp_cnt = 0;
    for (int i = 0; i < 260; i++) begin
      if (exp_cnt < 255) exp_cnt++;
      run_op(0, 15, 15, 14, 1, exp_cnt, -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=%0d required=<finished>", cycle);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/adder_arbiter.md
Name: adder_arbiter

Overview:
Round-robin controller that shares one registered adder (one-cycle capture on Clk when En=1) among N_REQ requesters. Per transaction it latches the winner's operands, drives the adder's enable for exactly one cycle, captures the sum/overflow, and returns it with a one-cycle Ack. A saturating overflow counter is kept for debug. Sits between client blocks and the shared adder datapath.

Parameters:
N_REQ, 4, number of requesters (2..8)
WIDTH, 4, operand/sum width; must match adder
ID_W, 2, grant index width, ceil(log2(N_REQ))

Ports:
Clk  input  1  clock, all state updates on posedge
Rst  input  1  synchronous, active-high reset
Req  input  N_REQ  per-requester request, level, held until Ack
ReqA  input  N_REQ*WIDTH  operand A, requester i at bits [i*WIDTH +: WIDTH]
ReqB  input  N_REQ*WIDTH  operand B, same packing
Ack  output  N_REQ  one-hot one-cycle completion pulse
Result  output  WIDTH  sum for the acked requester, held until next Ack
ResultOvf  output  1  carry-out for the acked requester, held with Result
GntId  output  ID_W  index of current/last granted requester
Busy  output  1  high in every state except IDLE
AddA  output  WIDTH  adder operand A (registered)
AddB  output  WIDTH  adder operand B (registered)
AddEn  output  1  adder enable (registered)
AddSum  input  WIDTH  adder registered sum
AddOverflow  input  1  adder registered carry-out
OvfCount  output  8  number of completed ops with ResultOvf=1, saturates at 255

Behaviour:
- Reset (Rst=1 at posedge, any state incl. mid-transaction): state=IDLE, Ptr=0, Ack=0, AddEn=0, AddA=AddB=0, Result=0, ResultOvf=0, GntId=0, Busy=0, OvfCount=0. In-flight op is dropped, no Ack issued.
- FSM states: IDLE, ISSUE, WAIT, RESP; each of ISSUE/WAIT/RESP lasts exactly one cycle.
- IDLE: if any Req bit=1 at posedge, pick winner = first set bit scanning Ptr, Ptr+1, ... mod N_REQ; register AddA/AddB from winner's slice, GntId=winner, go ISSUE. No Req -> stay IDLE.
- ISSUE: AddEn=1 this cycle only; adder captures at end of cycle. -> WAIT.
- WAIT: AddSum/AddOverflow valid; register into Result/ResultOvf; if ResultOvf-to-be =1 and OvfCount<255, OvfCount+1. -> RESP.
- RESP: Ack[GntId]=1 (only bit set), Ptr=(GntId+1) mod N_REQ. -> IDLE.
- Latency: Req sampled at edge ending cycle 0 -> AddEn high cycle 1 -> Ack high cycle 3. Throughput: one op per 4 cycles.
- Requester must drop Req (or present new operands) for the cycle after Ack; Req still high in IDLE after Ack is a new request.
- Operands are sampled only at grant; changes to ReqA/ReqB or Req dropping after grant do not affect the op; Ack still issued.
- Req changes in ISSUE/WAIT/RESP are ignored until IDLE.
- Arithmetic: no width extension here; sum is WIDTH bits, carry in ResultOvf (from AddOverflow), modulo 2^WIDTH wrap.
- Ptr wrap: winner N_REQ-1 -> Ptr=0. Single persistent requester is regranted every 4 cycles (no starvation; fairness only among simultaneous requesters).
- AddEn never high outside ISSUE; Ack never more than one bit, never outside RESP.

Test Plan:
- Reset mid-op: Req[0]=1 A=3 B=4, assert Rst during WAIT -> no Ack, all outputs zero, Busy=0 next cycle.
- Single op: Req[2]=1 A=5 B=6 -> AddEn high exactly cycle 1, Ack=4'b0100 cycle 3, Result=11, ResultOvf=0, GntId=2.
- Overflow: Req[1]=1 A=9 B=8 -> Result=1, ResultOvf=1, OvfCount 0->1; A=15 B=1 -> Result=0, ResultOvf=1, OvfCount=2.
- Round-robin: Req=4'b1111 held, each dropped after its Ack -> Ack order 0,1,2,3, 4 cycles apart; then Req=4'b1001 with Ptr=0 -> 0 then 3.
- Operand change after grant: Req[3] A=2 B=2, change A to 7 in ISSUE -> Result=4.
- Saturation: 260 overflowing ops (A=15 B=15) -> OvfCount stops at 255, Result=14 each time.
